// File: rtl/bcd_display_scanner_pkg.sv
// Shared definitions for the BCD display scanner: conversion FSM states,
// BCD nibble constants and a constant-evaluation power-of-ten helper.
package bcd_display_scanner_pkg;

  localparam int BCD_W = 4;

  // Code driven on bcd_digit while a leading-zero slot is blanked.
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'd0;

  // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift.
  localparam logic [BCD_W-1:0] DD_THRESH = 4'd5;
  localparam logic [BCD_W-1:0] DD_ADD    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // 10**n, evaluated at elaboration to derive the saturation value.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_display_scanner_bin2bcd_dd.sv
// Iterative double-dabble core: one add-3/shift iteration per clock,
// exactly BIN_W iterations after start, no early exit.
module bin2bcd_dd
  import bcd_display_scanner_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd
);

  localparam int BCD_BITS = BCD_W * DIGITS;
  localparam int SR_W     = BCD_BITS + BIN_W;
  localparam int CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] iter_q;
  logic             busy_q;

  // Add-3 correction applied to every BCD nibble ahead of the shift.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    sr_adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[BIN_W + BCD_W*i +: BCD_W] >= DD_THRESH)
        sr_adj[BIN_W + BCD_W*i +: BCD_W] = sr_q[BIN_W + BCD_W*i +: BCD_W] + DD_ADD;
    end
  end

  // Shift register and iteration counter; start reloads and restarts the conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (!rst_n) begin
      sr_q   <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      sr_q   <= SR_W'(bin);
      iter_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      // The top bit shifted out is always 0 for an in-range operand.
      sr_q   <= {sr_adj[SR_W-2:0], 1'b0};
      iter_q <= iter_q + CNT_W'(1);
      if (iter_q == LAST_ITER) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  // High during the cycle whose closing edge performs the final iteration.
  assign done = busy_q && (iter_q == LAST_ITER);
  assign bcd  = sr_q[SR_W-1 -: BCD_BITS];

endmodule

// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD display scanner: accepts a value over valid/ready, saturates it,
// converts it with the double-dabble core and time-multiplexes the digits
// onto bcd_digit / digit_sel with optional leading-zero blanking.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              bin_valid,
  output logic              bin_ready,
  output logic [3:0]        bcd_digit,
  output logic [DIGITS-1:0] digit_sel,
  output logic              ovf,
  output logic              done
);

  localparam int BCD_BITS = BCD_W * DIGITS;
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PS_W     = $clog2(SCAN_DIV);
  localparam logic [BIN_W-1:0] SAT_VAL  = BIN_W'(pow10(DIGITS) - 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t              state_q, state_d;
  logic                accept, load_display, sat_in, sat_q;
  logic                core_busy, core_done;
  logic [BIN_W-1:0]    core_bin;
  logic [BCD_BITS-1:0] core_bcd, display_q, display_d;
  logic [PS_W-1:0]     presc_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   blank_vec;
  logic                all_zero_above;

  // Out-of-range inputs are replaced by the all-nines value before conversion.
  assign sat_in   = (bin_in > SAT_VAL);
  assign core_bin = sat_in ? SAT_VAL : bin_in;

  bin2bcd_dd #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_dd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (core_bin),
    .busy  (core_busy),
    .done  (core_done),
    .bcd   (core_bcd)
  );

  // Conversion FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Conversion FSM next-state logic; a core that is no longer busy never stalls SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bin_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (core_done || !core_busy) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Conversion FSM outputs.
  always_comb begin
    bin_ready    = (state_q == ST_IDLE);
    accept       = bin_valid && (state_q == ST_IDLE);
    load_display = (state_q == ST_DONE);
  end

  // Saturation flag, display latch and done pulse; the display only changes in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q     <= 1'b0;
      display_q <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= load_display;
      if (accept) sat_q <= sat_in;
      if (load_display) begin
        display_q <= core_bcd;
        ovf       <= sat_q;
      end
    end
  end

  // Scan position after this edge, so registered outputs track the live index and display.
  always_comb begin
    idx_d = idx_q;
    if (presc_q == PS_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  end

  assign display_d = load_display ? core_bcd : display_q;

  // Leading-zero blank map: digit i>0 blanks when it and every higher nibble are zero.
  always_comb begin
    blank_vec      = '0;
    all_zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      all_zero_above = all_zero_above && (display_d[BCD_W*i +: BCD_W] == '0);
      blank_vec[i]   = (LZ_BLANK != 0) && all_zero_above;
    end
  end

  // Free-running prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
      idx_q   <= idx_d;
    end
  end

  // Registered digit and select, both updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_digit <= 4'd0;
      digit_sel <= DIGITS'(1);
    end else if (blank_vec[idx_d]) begin
      bcd_digit <= BLANK_CODE;
      digit_sel <= '0;
    end else begin
      bcd_digit <= display_d[BCD_W*idx_d +: BCD_W];
      digit_sel <= DIGITS'(1) << idx_d;
    end
  end

endmodule
